bsg_mesh_credit_link_sender: RTL and testbench

- Credit-based link transmitter that sits directly upstream of a mesh router input port configured with use_credits_p=1.
- Accepts packets from a local source over valid/ready, buffers them, and launches them onto the inter-tile link from a registered output stage.
- Launches only when it holds a credit.
- Credits return as single-cycle pulses, one per packet the downstream router input FIFO dequeues.

---
 rtl/bsg_mesh_credit_link_sender_if.sv | 33 +++
 rtl/bsg_mesh_credit_link_sender.sv | 164 ++++++++++++++++
 tb/tb_bsg_mesh_credit_link_sender.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_mesh_credit_link_sender_if.sv
// Source-side valid/ready handshake plus the credit-governed link toward the router.
// Latency: none (wires only).
// Backpressure: ready_o throttles the source; the link itself never stalls, credits gate it.
interface bsg_mesh_credit_link_sender_if #(
  parameter int width_p = 8
);
  logic               v_i;
  logic [width_p-1:0] data_i;
  logic               ready_o;
  logic               link_v_o;
  logic [width_p-1:0] link_data_o;
  logic               link_credit_i;

  // Transmitter view: takes packets and credits, drives ready and the link.
  modport master (
    input  v_i,
    input  data_i,
    input  link_credit_i,
    output ready_o,
    output link_v_o,
    output link_data_o
  );

  // Environment view: packet source plus the downstream router returning credits.
  modport slave (
    output v_i,
    output data_i,
    output link_credit_i,
    input  ready_o,
    input  link_v_o,
    input  link_data_o
  );
endinterface

// File: rtl/bsg_mesh_credit_link_sender.sv
// Generic synchronous FIFO used as the sender's local packet buffer.
// Latency: one cycle from enqueue to head visible (first-word-fall-through after the write).
// Backpressure: enq_rdy is ~full (and low in reset); no bypass, so a full FIFO refuses even while draining.
module bsg_mesh_credit_link_fifo #(
  parameter  int width_p      = 8,
  parameter  int els_p        = 2,
  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int cnt_width_lp = $clog2(els_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enq_vld,
  input  logic [width_p-1:0] enq_dat,
  output logic               enq_rdy,
  output logic               deq_vld,
  output logic [width_p-1:0] deq_dat,
  input  logic               deq_rdy
);

  logic [width_p-1:0]      mem_r [els_p];
  logic [ptr_width_lp-1:0] rd_ptr_r;
  logic [ptr_width_lp-1:0] wr_ptr_r;
  logic [cnt_width_lp-1:0] cnt_r;
  logic                    full;
  logic                    empty;
  logic                    enq;
  logic                    deq;

  // Pointers wrap explicitly so depths that are not a power of two work.
  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_r == cnt_width_lp'(els_p));
  assign empty   = (cnt_r == '0);
  assign enq_rdy = ~full & ~reset_i;
  assign deq_vld = ~empty;
  assign deq_dat = mem_r[rd_ptr_r];
  assign enq     = enq_vld & enq_rdy;
  assign deq     = deq_rdy & ~empty;

  // Storage array; contents need no reset because occupancy is tracked separately.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_r[wr_ptr_r] <= enq_dat;
    end
  end

  // Pointer and occupancy bookkeeping; reset empties the buffer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (enq) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (deq) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({enq, deq})
        2'b10:   cnt_r <= cnt_r + 1'b1;
        2'b01:   cnt_r <= cnt_r - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// Credit-based link transmitter feeding a mesh router input port that runs in credit mode.
// Latency: two cycles minimum from source acceptance to link_v_o (buffer write, then output register).
// Backpressure: ready_o drops when the local buffer is full; launches wait for a nonzero credit count.
module bsg_mesh_credit_link_sender #(
  parameter  int width_p         = -1,
  parameter  int credits_p       = 2,
  parameter  int buf_els_p       = 2,
  localparam int credit_width_lp = $clog2(credits_p + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  bsg_mesh_credit_link_sender_if.master     link_if,
  output logic [credit_width_lp-1:0]        credit_count_o,
  output logic                              idle_o
);

  localparam logic [credit_width_lp-1:0] credits_full_lp = credit_width_lp'(credits_p);

  logic                       buf_vld;
  logic [width_p-1:0]         buf_dat;
  logic                       send;
  logic [credit_width_lp-1:0] credit_cnt_r;
  logic [credit_width_lp-1:0] credit_cnt_n;
  logic                       credit_overflow;
  logic                       link_v_r;
  logic [width_p-1:0]         link_data_r;

  bsg_mesh_credit_link_fifo #(
    .width_p (width_p),
    .els_p   (buf_els_p)
  ) pkt_buf (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .enq_vld (link_if.v_i),
    .enq_dat (link_if.data_i),
    .enq_rdy (link_if.ready_o),
    .deq_vld (buf_vld),
    .deq_dat (buf_dat),
    .deq_rdy (send)
  );

  // A packet launches whenever one is waiting and the router has room for it.
  assign send = buf_vld & (credit_cnt_r != '0);

  // Credit arithmetic: a launch spends one, a returned pulse restores one; both cancel.
  // A return that would exceed the downstream FIFO depth is a router protocol error and is dropped.
  always_comb begin
    credit_cnt_n    = credit_cnt_r;
    credit_overflow = 1'b0;
    case ({send, link_if.link_credit_i})
      2'b10: credit_cnt_n = credit_cnt_r - 1'b1;
      2'b01: begin
        if (credit_cnt_r == credits_full_lp) begin
          credit_overflow = 1'b1;
        end else begin
          credit_cnt_n = credit_cnt_r + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Credit register; reset restores the full downstream depth and ignores pulses during reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      credit_cnt_r <= credits_full_lp;
    end else begin
      credit_cnt_r <= credit_cnt_n;
    end
  end

  // Registered link stage: valid for exactly one cycle per launch, data held between launches.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      link_v_r    <= 1'b0;
      link_data_r <= '0;
    end else begin
      link_v_r <= send;
      if (send) begin
        link_data_r <= buf_dat;
      end
    end
  end

  assign link_if.link_v_o    = link_v_r;
  assign link_if.link_data_o = link_data_r;
  assign credit_count_o      = credit_cnt_r;
  assign idle_o              = ~buf_vld & ~link_v_r & (credit_cnt_r == credits_full_lp);

  credit_return_overflow: assert property (@(posedge clk_i) disable iff (reset_i) !credit_overflow)
    else $error("bsg_mesh_credit_link_sender: credit returned while already holding %0d credits", credits_p);

endmodule

// File: tb/tb_bsg_mesh_credit_link_sender.sv
// Self-checking bench: queue-based reference model compared every cycle, directed scenarios with
// literal expectations, randomized traffic against a credit-returning router model.
module tb_bsg_mesh_credit_link_sender;

  localparam int W    = 8;
  localparam int CRED = 2;
  localparam int BUF  = 2;
  localparam int CW   = $clog2(CRED + 1);

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic [CW-1:0] credit_count_o;
  logic          idle_o;

  bsg_mesh_credit_link_sender_if #(.width_p(W)) intf();

  bsg_mesh_credit_link_sender #(
    .width_p   (W),
    .credits_p (CRED),
    .buf_els_p (BUF)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .link_if        (intf),
    .credit_count_o (credit_count_o),
    .idle_o         (idle_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  bit fire = 1'b0;

  // Reference model: buffer contents, credits, expected link register.
  logic [W-1:0] mq[$];
  int           mcnt = CRED;
  bit           mlv = 1'b0;
  logic [W-1:0] mld = '0;
  bit           m_send;
  bit           m_acc;

  logic [W-1:0] src[$];
  logic [W-1:0] sb[$];
  logic [W-1:0] rq[$];
  logic [W-1:0] got[$];
  int           gotc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advance: a packet launches when buffered and a credit is held; credits spent/returned.
  always @(posedge clk) begin
    if (reset_i) begin
      mq.delete();
      mcnt = CRED;
      mlv  = 1'b0;
      mld  = '0;
    end else begin
      m_send = (mq.size() > 0) && (mcnt > 0);
      m_acc  = intf.v_i && (mq.size() < BUF);
      if (m_send) begin
        mlv = 1'b1;
        mld = mq.pop_front();
      end else begin
        mlv = 1'b0;
      end
      mcnt = mcnt - int'(m_send) + int'(intf.link_credit_i);
      if (mcnt > CRED) mcnt = CRED;
      if (m_acc) mq.push_back(intf.data_i);
    end
  end

  // Per-cycle comparison of every output against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready_o", intf.ready_o, (!reset_i && mq.size() < BUF));
      chk("link_v_o", intf.link_v_o, mlv);
      chk("link_data_o", intf.link_data_o, mld);
      chk("credit_count_o", credit_count_o, mcnt);
      chk("idle_o", idle_o, (mq.size() == 0 && !mlv && mcnt == CRED));
    end
  end

  task automatic tick();
    #1;
    fire = intf.v_i && intf.ready_o;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_src();
    if (src.size() > 0) begin
      intf.v_i    = 1'b1;
      intf.data_i = src[0];
    end else begin
      intf.v_i = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rate;
    bit done;
    intf.v_i = 1'b0;
    intf.data_i = '0;
    intf.link_credit_i = 1'b0;
    reset_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Reset state
    reset_i = 1'b0;
    #1;
    chk("rst_ready", intf.ready_o, 1);
    chk("rst_link_v", intf.link_v_o, 0);
    chk("rst_link_data", intf.link_data_o, 0);
    chk("rst_count", credit_count_o, CRED);
    chk("rst_idle", idle_o, 1);

    // Single packet: accepted cycle 0, on link cycle 2
    intf.v_i = 1'b1;
    intf.data_i = 8'hA5;
    tick();
    intf.v_i = 1'b0;
    chk("single_c1_link_v", intf.link_v_o, 0);
    chk("single_c1_count", credit_count_o, 2);
    tick();
    chk("single_c2_link_v", intf.link_v_o, 1);
    chk("single_c2_data", intf.link_data_o, 8'hA5);
    chk("single_c2_count", credit_count_o, 1);
    chk("single_c2_idle", idle_o, 0);
    tick();
    chk("single_c3_idle", idle_o, 0);
    intf.link_credit_i = 1'b1;
    tick();
    intf.link_credit_i = 1'b0;
    chk("single_ret_count", credit_count_o, 2);
    chk("single_ret_idle", idle_o, 1);

    // Credit exhaustion: five back-to-back packets, no credits returned
    src = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    drive_src();
    for (int i = 0; i < 12; i++) begin
      tick();
      if (fire) void'(src.pop_front());
      if (intf.link_v_o) begin
        got.push_back(intf.link_data_o);
        gotc.push_back(i);
      end
      drive_src();
    end
    chk("exh_npkts", got.size(), 2);
    if (got.size() == 2) begin
      chk("exh_pkt0", got[0], 1);
      chk("exh_pkt1", got[1], 2);
      chk("exh_consecutive", gotc[1] - gotc[0], 1);
    end
    chk("exh_ready", intf.ready_o, 0);
    chk("exh_count", credit_count_o, 0);
    chk("exh_src_left", src.size(), 1);

    // Credit return resumes: pulse at c, packet 3 at c+2
    intf.link_credit_i = 1'b1;
    tick();
    if (fire) void'(src.pop_front());
    intf.link_credit_i = 1'b0;
    chk("resume_c1_count", credit_count_o, 1);
    chk("resume_c1_link_v", intf.link_v_o, 0);
    tick();
    if (fire) void'(src.pop_front());
    drive_src();
    chk("resume_c2_link_v", intf.link_v_o, 1);
    chk("resume_c2_data", intf.link_data_o, 3);
    chk("resume_c2_count", credit_count_o, 0);
    tick();
    if (fire) void'(src.pop_front());
    drive_src();
    chk("resume_src_empty", src.size(), 0);

    // Simultaneous send and credit return keep the count at 1
    intf.link_credit_i = 1'b1;
    tick();
    chk("simul_d1_count", credit_count_o, 1);
    tick();
    intf.link_credit_i = 1'b0;
    chk("simul_d2_count", credit_count_o, 1);
    chk("simul_d2_link_v", intf.link_v_o, 1);
    chk("simul_d2_data", intf.link_data_o, 4);
    tick();
    chk("simul_d3_link_v", intf.link_v_o, 1);
    chk("simul_d3_data", intf.link_data_o, 5);
    chk("simul_d3_count", credit_count_o, 0);
    tick();
    // Return the two credits still owed
    intf.link_credit_i = 1'b1;
    tick();
    intf.link_credit_i = 1'b0;
    tick();
    intf.link_credit_i = 1'b1;
    tick();
    intf.link_credit_i = 1'b0;
    chk("simul_restore_count", credit_count_o, CRED);
    chk("simul_restore_idle", idle_o, 1);

    // Randomized traffic against a router that drains its FIFO at a varying rate
    rq.delete();
    sb.delete();
    intf.v_i = 1'b0;
    rate = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) rate = int'($urandom_range(0, 4));
      tick();
      if (fire) sb.push_back(intf.data_i);
      if (intf.link_v_o) begin
        if (sb.size() == 0) chk("rand_unexpected_pkt", 1, 0);
        else chk("rand_order", intf.link_data_o, sb.pop_front());
      end
      intf.link_credit_i = 1'b0;
      if (rq.size() > 0 && int'($urandom_range(0, 3)) < rate) begin
        void'(rq.pop_front());
        intf.link_credit_i = 1'b1;
      end
      if (intf.link_v_o) rq.push_back(intf.link_data_o);
      chk("rand_router_depth", (rq.size() <= CRED), 1);
      chk("rand_count_range", (credit_count_o <= CRED), 1);
      if (!intf.v_i || fire) begin
        if ($urandom_range(0, 3) != 0) begin
          intf.v_i = 1'b1;
          intf.data_i = W'($urandom);
        end else begin
          intf.v_i = 1'b0;
        end
      end
    end

    // Drain: stop the source and let the router return everything
    intf.v_i = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (intf.link_v_o) begin
        if (sb.size() == 0) chk("drain_unexpected_pkt", 1, 0);
        else chk("drain_order", intf.link_data_o, sb.pop_front());
      end
      intf.link_credit_i = 1'b0;
      if (rq.size() > 0) begin
        void'(rq.pop_front());
        intf.link_credit_i = 1'b1;
      end
      if (intf.link_v_o) rq.push_back(intf.link_data_o);
      done = (rq.size() == 0) && !intf.link_credit_i && idle_o && (sb.size() == 0);
    end
    chk("drain_done", done, 1);
    chk("drain_sb_empty", sb.size(), 0);
    intf.link_credit_i = 1'b0;
    tick();
    chk("drain_idle", idle_o, 1);

    // Reset mid-stream with two buffered packets and no credits
    src = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive_src();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fire) void'(src.pop_front());
      drive_src();
    end
    chk("mid_pre_count", credit_count_o, 0);
    chk("mid_pre_ready", intf.ready_o, 0);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    #1;
    chk("mid_link_v", intf.link_v_o, 0);
    chk("mid_count", credit_count_o, CRED);
    chk("mid_ready", intf.ready_o, 1);
    chk("mid_idle", idle_o, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mid_no_stale_pkt", intf.link_v_o, 0);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
